// File: rtl/tank_pkg.sv
// Shared types and the grid-step helper used by the tank and bullet logic.
package tank_pkg;

    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;
    localparam int COORD_W    = 6;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_FLY  = 1'b1
    } bstate_t;

    typedef struct packed {
        logic   ok;
        coord_t x;
        coord_t y;
    } step_t;

    // One cell step; bounds are checked before any decrement so nothing wraps.
    function automatic step_t step_cell(input coord_t x, input coord_t y, input dir_t d,
                                        input coord_t gw, input coord_t gh);
        step_t r;
        r.ok = 1'b1;
        r.x  = x;
        r.y  = y;
        case (d)
            DIR_UP: begin
                if (y == '0) r.ok = 1'b0;
                else         r.y  = y - coord_t'(1);
            end
            DIR_RIGHT: begin
                if (x >= gw - coord_t'(1)) r.ok = 1'b0;
                else                       r.x  = x + coord_t'(1);
            end
            DIR_DOWN: begin
                if (y >= gh - coord_t'(1)) r.ok = 1'b0;
                else                       r.y  = y + coord_t'(1);
            end
            default: begin
                if (x == '0) r.ok = 1'b0;
                else         r.x  = x - coord_t'(1);
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tank_ctrl_tick_gen.sv
// Free-running divider: one-cycle tick when the count reaches DIV-1; holds while disabled.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign o_tick = i_en && (cnt_reg == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (i_en) begin
            if (o_tick) cnt_reg <= '0;
            else        cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/tank_ctrl.sv
// Tank position/facing and single-bullet logic. Define TANK_WRAP_EN for toroidal tank movement.
module tank_ctrl
    import tank_pkg::*;
#(
    parameter int GRID_W     = GRID_W_DEF,
    parameter int GRID_H     = GRID_H_DEF,
    parameter int MOVE_DIV   = 2500000,
    parameter int BULLET_DIV = 625000,
    parameter int INIT_X     = 2,
    parameter int INIT_Y     = 2,
    parameter int INIT_DIR   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    output logic [5:0] o_tank_x,
    output logic [5:0] o_tank_y,
    output logic [1:0] o_tank_dir,
    output logic       o_bullet_valid,
    output logic [5:0] o_bullet_x,
    output logic [5:0] o_bullet_y,
    output logic       o_fire_pulse
);

    localparam coord_t GW         = coord_t'(GRID_W);
    localparam coord_t GH         = coord_t'(GRID_H);
    localparam coord_t INIT_X_C   = coord_t'(INIT_X);
    localparam coord_t INIT_Y_C   = coord_t'(INIT_Y);
    localparam dir_t   INIT_DIR_C = dir_t'(2'(INIT_DIR));

    logic move_tick;
    logic bullet_tick;

    tick_gen #(.DIV(MOVE_DIV)) u_move_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_enable),
        .o_tick (move_tick)
    );

    tick_gen #(.DIV(BULLET_DIV)) u_bullet_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_enable),
        .o_tick (bullet_tick)
    );

    coord_t  tank_x_reg,   tank_x_next;
    coord_t  tank_y_reg,   tank_y_next;
    dir_t    tank_dir_reg, tank_dir_next;
    bstate_t bstate_reg,   bstate_next;
    coord_t  bullet_x_reg, bullet_x_next;
    coord_t  bullet_y_reg, bullet_y_next;
    dir_t    bullet_dir_reg, bullet_dir_next;
    logic    fire_pulse_reg, fire_pulse_next;
    logic    fire_prev_reg;

    logic  req_valid;
    dir_t  req_dir;
    logic  fire_edge;
    logic  spawn;
    step_t ahead;
    step_t move_step;
    step_t bullet_step;

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if      (i_up)    req_dir = DIR_UP;
        else if (i_down)  req_dir = DIR_DOWN;
        else if (i_left)  req_dir = DIR_LEFT;
        else if (i_right) req_dir = DIR_RIGHT;
        else              req_valid = 1'b0;
    end

    assign fire_edge   = i_fire & ~fire_prev_reg;
    assign ahead       = step_cell(tank_x_reg, tank_y_reg, tank_dir_reg, GW, GH);
    assign move_step   = step_cell(tank_x_reg, tank_y_reg, req_dir, GW, GH);
    assign bullet_step = step_cell(bullet_x_reg, bullet_y_reg, bullet_dir_reg, GW, GH);
    assign spawn       = i_enable && fire_edge && (bstate_reg == B_IDLE) && ahead.ok;

    // Tank movement: direction always follows the request, position only if the step is legal.
    always_comb begin
        tank_x_next   = tank_x_reg;
        tank_y_next   = tank_y_reg;
        tank_dir_next = tank_dir_reg;
        if (move_tick && req_valid) begin
            tank_dir_next = req_dir;
            if (move_step.ok) begin
                tank_x_next = move_step.x;
                tank_y_next = move_step.y;
            end
`ifdef TANK_WRAP_EN
            else begin
                case (req_dir)
                    DIR_UP:    tank_y_next = GH - coord_t'(1);
                    DIR_RIGHT: tank_x_next = '0;
                    DIR_DOWN:  tank_y_next = '0;
                    default:   tank_x_next = GW - coord_t'(1);
                endcase
            end
`else
            else begin
                tank_x_next = tank_x_reg;
                tank_y_next = tank_y_reg;
            end
`endif
        end
    end

    // Bullet FSM; spawning only happens from idle, so a spawn never coincides with an advance.
    always_comb begin
        bstate_next     = bstate_reg;
        bullet_x_next   = bullet_x_reg;
        bullet_y_next   = bullet_y_reg;
        bullet_dir_next = bullet_dir_reg;
        fire_pulse_next = 1'b0;
        case (bstate_reg)
            B_IDLE: begin
                if (spawn) begin
                    bstate_next     = B_FLY;
                    bullet_x_next   = ahead.x;
                    bullet_y_next   = ahead.y;
                    bullet_dir_next = tank_dir_reg;
                    fire_pulse_next = 1'b1;
                end
            end
            default: begin
                if (bullet_tick) begin
                    if (bullet_step.ok) begin
                        bullet_x_next = bullet_step.x;
                        bullet_y_next = bullet_step.y;
                    end else begin
                        bstate_next = B_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tank_x_reg     <= INIT_X_C;
            tank_y_reg     <= INIT_Y_C;
            tank_dir_reg   <= INIT_DIR_C;
            bstate_reg     <= B_IDLE;
            bullet_x_reg   <= '0;
            bullet_y_reg   <= '0;
            bullet_dir_reg <= DIR_UP;
            fire_pulse_reg <= 1'b0;
            fire_prev_reg  <= 1'b0;
        end else begin
            tank_x_reg     <= tank_x_next;
            tank_y_reg     <= tank_y_next;
            tank_dir_reg   <= tank_dir_next;
            bstate_reg     <= bstate_next;
            bullet_x_reg   <= bullet_x_next;
            bullet_y_reg   <= bullet_y_next;
            bullet_dir_reg <= bullet_dir_next;
            fire_pulse_reg <= fire_pulse_next;
            fire_prev_reg  <= i_fire;
        end
    end

    assign o_tank_x       = tank_x_reg;
    assign o_tank_y       = tank_y_reg;
    assign o_tank_dir     = tank_dir_reg;
    assign o_bullet_valid = (bstate_reg == B_FLY);
    assign o_bullet_x     = bullet_x_reg;
    assign o_bullet_y     = bullet_y_reg;
    assign o_fire_pulse   = fire_pulse_reg;

endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
- Game-logic stage between the joystick front-end and the VGA renderer.
- Consumes synchronized joystick levels (up/down/left/right/fire) and holds tank 0's grid position and facing direction, driving the renderer's tank x/y/dir inputs.
- Owns one bullet: spawns on fire, advances on a rate tick, expires at the grid edge.
- Runs only while the game state enables it.

Parameters:
- GRID_W, 40, grid columns (cells 0..GRID_W-1).
- GRID_H, 30, grid rows (cells 0..GRID_H-1).
- MOVE_DIV, 2500000, clk cycles per tank move tick.
- BULLET_DIV, 625000, clk cycles per bullet advance tick.
- INIT_X, 2, tank column after reset.
- INIT_Y, 2, tank row after reset.
- INIT_DIR, 0, tank direction after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  game running; 0 freezes all state
- i_up  in  1  joystick up level, active-high, already synchronized
- i_down  in  1  joystick down level
- i_left  in  1  joystick left level
- i_right  in  1  joystick right level
- i_fire  in  1  joystick fire level
- o_tank_x  out  6  tank column
- o_tank_y  out  6  tank row
- o_tank_dir  out  2  facing: 0 up, 1 right, 2 down, 3 left
- o_bullet_valid  out  1  bullet in flight
- o_bullet_x  out  6  bullet column
- o_bullet_y  out  6  bullet row
- o_fire_pulse  out  1  one-cycle strobe on bullet spawn

Behaviour:
- Reset (async, rst=1):
  - tank x/y/dir = INIT_X/INIT_Y/INIT_DIR.
  - o_bullet_valid=0, o_bullet_x=0, o_bullet_y=0, o_fire_pulse=0.
  - Both tick counters=0; fire edge register=0.
  - Reset mid-flight kills the bullet immediately.
- Tick generators:
  - Counter runs 0..DIV-1 while i_enable=1 and wraps to 0.
  - Tick is asserted in the cycle the counter equals DIV-1.
  - i_enable=0 holds the counter value (no clear) and suppresses ticks.
- Direction request:
  - Priority up > down > left > right; none pressed means no request.
  - Requests are sampled only on a move tick.
- Tank move, on a move tick with a request (outputs update at that clock edge):
  - o_tank_dir is set to the requested direction.
  - Target cell = current cell + one step in the requested direction (up decrements y, left decrements x).
  - If the target is in [0,GRID_W-1]x[0,GRID_H-1], the position moves there; otherwise the position holds and the direction still updates.
- Fire:
  - A rising edge of i_fire (registered previous value) is a fire request.
  - If o_bullet_valid=0 and the cell one step ahead of the current (pre-update) position/direction is in bounds: next cycle o_bullet_valid=1, bullet=that cell, o_fire_pulse=1 for exactly one cycle.
  - If that cell is out of bounds, or a bullet is already in flight, the request is dropped; no queueing.
- Bullet FSM, states B_IDLE and B_FLY:
  - B_IDLE -> B_FLY on a spawn. The bullet direction is latched at spawn and is independent of later tank turns.
  - B_FLY on a bullet tick: if the next cell is in bounds, advance; otherwise go to B_IDLE with o_bullet_valid=0 and x/y holding their last value.
  - A spawn and a bullet tick in the same cycle: spawn wins, no advance that cycle.
- Simultaneous move tick and fire: spawn uses pre-move position/direction; the tank moves on the same edge.
- i_enable=0: no moves, no spawns (edge register still tracks i_fire), bullet frozen in place, all outputs hold.
- Width rule: coordinates are unsigned 6-bit. Bounds checks compare before decrement, so no underflow wrap leaks out.

Optional Feature:
- Macro TANK_WRAP_EN.
- Defined: tank movement wraps toroidally (x=GRID_W-1 stepping right -> 0, x=0 stepping left -> GRID_W-1; same for y).
- Not defined: clamp at walls as above.
- Bullets always expire at edges, regardless of the macro.

Decomposition:
- Package tank_pkg holds:
  - dir_t enum (DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3).
  - Default GRID_W/GRID_H constants.
  - Coordinate typedef coord_t (6-bit).
  - Bullet-state enum.
  - A pure step/in-bounds function shared by tank and bullet logic.
- One sub-module: tick_gen (parameter DIV; ports clk, rst, i_en, o_tick), instantiated twice for move and bullet ticks.

Test Plan:
- Bench overrides: MOVE_DIV=4, BULLET_DIV=2, GRID 8x8.
- Reset then release, hold i_right -> dir=1, x steps 2,3,4,... one per 4 cycles; x stops at 7 while dir stays 1 (with TANK_WRAP_EN: 7 -> 0).
- At (2,0), press i_up -> dir becomes 0, y stays 0; press i_up+i_left together -> up chosen.
- Tank (2,2) dir right, pulse i_fire -> next cycle o_fire_pulse=1 for 1 cycle, bullet (3,2), valid=1; bullet reaches x=7, then valid=0 on the following bullet tick.
- Second fire edge while bullet in flight -> no o_fire_pulse, bullet unchanged.
- Fire while holding i_fire high across ticks -> only one spawn.
- Tank at (7,3) facing right, fire -> dropped, valid stays 0.
- i_enable=0 mid-flight for 20 cycles -> all outputs frozen.
- Bullet in flight, assert rst mid-cycle -> valid=0 immediately, tank back at (2,2) dir 0.
